// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pkg : 7-segment code table and occupancy encoding (rev 1.0)      |
// +----------------------------------------------------------------------+
package seg_pkg;

  // Active-low patterns, bit6=g .. bit0=a
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] OCC_EMPTY     = 2'd0;
  localparam logic [1:0] OCC_FULL      = 2'd1;
  localparam logic [1:0] OCC_FULL_PEND = 2'd2;

  // Returns {valid, nibble}; valid=0 for blank and for unknown codes.
  function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'h00;
    case (seg)
      SEG_0:   res = 5'h10;
      SEG_1:   res = 5'h11;
      SEG_2:   res = 5'h12;
      SEG_3:   res = 5'h13;
      SEG_4:   res = 5'h14;
      SEG_5:   res = 5'h15;
      SEG_6:   res = 5'h16;
      SEG_7:   res = 5'h17;
      SEG_8:   res = 5'h18;
      SEG_9:   res = 5'h19;
      SEG_A:   res = 5'h1A;
      SEG_B:   res = 5'h1B;
      SEG_C:   res = 5'h1C;
      SEG_D:   res = 5'h1D;
      SEG_E:   res = 5'h1E;
      SEG_F:   res = 5'h1F;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_sync : 2-flop synchroniser, resets to all-ones (rev 1.0)         |
// +----------------------------------------------------------------------+
module seg_sync #(
  parameter int WIDTH = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule
`default_nettype wire

// File: rtl/seg_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_decoder : filters a 7-seg bus and streams decoded nibbles (rev 1.0)|
// +----------------------------------------------------------------------+
module seg_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [6:0]       i_seg,
  input  logic             i_ready,
  output logic [3:0]       o_hex,
  output logic             o_valid,
  output logic             o_err,
  output logic             o_overrun,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int              CNT_W     = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [6:0]       w_s2;
  logic [6:0]       r_cand;
  logic [6:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             w_evt;
  logic [4:0]       w_dec;
  logic             w_evt_digit;
  logic             w_evt_inv;
  logic             r_err;
  logic [ERR_W-1:0] r_err_cnt;
  logic [1:0]       r_occ;
  logic [1:0]       w_occ_nxt;
  logic             w_valid;
  logic             w_xfer;
  logic             w_ld_hex_evt;
  logic             w_ld_hex_pend;
  logic             w_ld_pend;
  logic             w_ovr;
  logic [3:0]       r_hex;
  logic [3:0]       r_pend;
  logic             r_ovr;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  seg_sync #(.WIDTH(7)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (w_rst_n),
    .i_d     (i_seg),
    .o_q     (w_s2)
  );

  assign w_evt       = (r_cnt == c_CNT_MAX) && (r_cand != r_last);
  assign w_dec       = seg_to_hex(r_cand);
  assign w_evt_digit = w_evt & w_dec[4];
  assign w_evt_inv   = w_evt & ~w_dec[4] & (r_cand != SEG_BLANK);

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cand <= SEG_BLANK;
      r_last <= SEG_BLANK;
      r_cnt  <= '0;
    end else begin
      if (w_s2 != r_cand) begin
        r_cand <= w_s2;
        r_cnt  <= '0;
      end else if (r_cnt < c_CNT_MAX) begin
        r_cnt  <= r_cnt + 1'b1;
      end
      if (w_evt) r_last <= r_cand;
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_evt_inv;
      if (w_evt_inv && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  // Output/pending occupancy: state register
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_occ <= OCC_EMPTY;
    else          r_occ <= w_occ_nxt;
  end

  assign w_xfer = w_valid & i_ready;

  always_comb begin
    w_occ_nxt = r_occ;
    case (r_occ)
      OCC_EMPTY:     if (w_evt_digit) w_occ_nxt = OCC_FULL;
      OCC_FULL:      if (w_xfer)      w_occ_nxt = w_evt_digit ? OCC_FULL : OCC_EMPTY;
                     else if (w_evt_digit) w_occ_nxt = OCC_FULL_PEND;
      OCC_FULL_PEND: if (w_xfer)      w_occ_nxt = w_evt_digit ? OCC_FULL_PEND : OCC_FULL;
      default:       w_occ_nxt = OCC_EMPTY;
    endcase
  end

  always_comb begin
    w_valid       = (r_occ != OCC_EMPTY);
    w_ld_hex_evt  = 1'b0;
    w_ld_hex_pend = 1'b0;
    w_ld_pend     = 1'b0;
    w_ovr         = 1'b0;
    case (r_occ)
      OCC_EMPTY: w_ld_hex_evt = w_evt_digit;
      OCC_FULL: begin
        if (w_xfer) w_ld_hex_evt = w_evt_digit;
        else        w_ld_pend    = w_evt_digit;
      end
      OCC_FULL_PEND: begin
        w_ld_pend = w_evt_digit;
        if (w_xfer) w_ld_hex_pend = 1'b1;
        else        w_ovr         = w_evt_digit;
      end
      default: w_valid = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hex  <= 4'h0;
      r_pend <= 4'h0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_ld_hex_evt)       r_hex <= w_dec[3:0];
      else if (w_ld_hex_pend) r_hex <= r_pend;
      if (w_ld_pend)          r_pend <= w_dec[3:0];
      r_ovr <= w_ovr;
    end
  end

  assign o_hex     = r_hex;
  assign o_valid   = w_valid;
  assign o_err     = r_err;
  assign o_overrun = r_ovr;
  assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seg_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg_decoder : scoreboard bench for seg_decoder (rev 1.0)          |
// +----------------------------------------------------------------------+
module tb_seg_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] seg = 7'h7F;
  logic       ready = 1'b1;

  logic [3:0] o_hex;
  logic        o_valid, o_err, o_overrun;
  logic [7:0]  o_err_cnt;
  logic [3:0]  d2_hex;
  logic        d2_valid, d2_err, d2_overrun;
  logic [1:0]  d2_err_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int n_err_pulse = 0;
  int n_ovr_pulse = 0;
  logic [3:0] sb[$];
  bit         prev_stall = 1'b0;
  logic [3:0] prev_hex = 4'h0;

  seg_decoder #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_seg(seg), .i_ready(ready),
    .o_hex(o_hex), .o_valid(o_valid), .o_err(o_err),
    .o_overrun(o_overrun), .o_err_cnt(o_err_cnt)
  );

  seg_decoder #(.STABLE_CYCLES(4), .ERR_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_seg(seg), .i_ready(ready),
    .o_hex(d2_hex), .o_valid(d2_valid), .o_err(d2_err),
    .o_overrun(d2_overrun), .o_err_cnt(d2_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) chk("hold", {o_valid, o_hex}, {1'b1, prev_hex});
      if (o_valid && ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got hex %0h, scoreboard empty", o_hex);
        end else begin
          chk("hex", {28'h0, o_hex}, {28'h0, sb.pop_front()});
        end
      end
      if (o_err)     n_err_pulse++;
      if (o_overrun) n_ovr_pulse++;
      prev_stall = o_valid && !ready;
      prev_hex   = o_hex;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int e0;
    int ovr0;
    #1 rst_n = 1'b0;
    cyc(3);
    chk("rst_valid", o_valid, 0);
    chk("rst_hex", o_hex, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ovr", o_overrun, 0);
    chk("rst_errcnt", o_err_cnt, 0);
    rst_n = 1'b1;
    cyc(5);

    // 1: single digit, latency and one-cycle valid
    seg = 7'h24; sb.push_back(4'h2);
    cyc(6); chk("t1_lat6_valid", o_valid, 0);
    cyc(1); chk("t1_lat7_valid", o_valid, 1);
    chk("t1_hex", o_hex, 4'h2);
    cyc(1); chk("t1_valid_drop", o_valid, 0);
    cyc(5);

    // 2: glitching bus settles on 3
    for (int i = 0; i < 6; i++) begin
      seg = (i % 2) ? 7'h30 : 7'h24;
      cyc(2);
    end
    seg = 7'h30; sb.push_back(4'h3);
    cyc(12);
    chk("t2_drain", sb.size(), 0);

    // 3: stalled output, pending overwrite
    ready = 1'b0;
    seg = 7'h79; sb.push_back(4'h1);
    cyc(10);
    chk("t3_valid", o_valid, 1);
    chk("t3_hex1", o_hex, 4'h1);
    seg = 7'h40;
    cyc(10);
    chk("t3_hex_held", o_hex, 4'h1);
    ovr0 = n_ovr_pulse;
    seg = 7'h78; sb.push_back(4'h7);
    cyc(10);
    chk("t3_overrun", n_ovr_pulse - ovr0, 1);
    ready = 1'b1;
    cyc(5);
    chk("t3_drain", sb.size(), 0);

    // 4: invalid codes and counter saturation
    e0 = n_err_pulse;
    seg = 7'h7E;
    cyc(10);
    chk("t4_err_pulse", n_err_pulse - e0, 1);
    chk("t4_errcnt1", o_err_cnt, 1);
    chk("t4_no_valid", o_valid, 0);
    seg = 7'h7D; cyc(10);
    seg = 7'h7B; cyc(10);
    seg = 7'h77; cyc(10);
    seg = 7'h6F; cyc(10);
    chk("t4_err_pulses5", n_err_pulse - e0, 5);
    chk("t4_errcnt5", o_err_cnt, 5);
    chk("t4_sat_errcnt", d2_err_cnt, 3);

    // 5: blank separates repeated digit
    e0 = n_err_pulse;
    seg = 7'h40; sb.push_back(4'h0); cyc(10);
    seg = 7'h7F; cyc(10);
    seg = 7'h40; sb.push_back(4'h0); cyc(10);
    chk("t5_no_err", n_err_pulse - e0, 0);
    chk("t5_drain", sb.size(), 0);

    // 6: async reset with output and pending full
    ready = 1'b0;
    seg = 7'h79; cyc(10);
    seg = 7'h12; cyc(10);
    chk("t6_valid_before", o_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", o_valid, 0);
    chk("t6_rst_hex", o_hex, 0);
    chk("t6_rst_err", o_err, 0);
    chk("t6_rst_ovr", o_overrun, 0);
    chk("t6_rst_errcnt", o_err_cnt, 0);
    sb.delete();
    seg = 7'h7F;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    chk("t6_valid_after", o_valid, 0);
    ready = 1'b1;
    seg = 7'h0E; sb.push_back(4'hF);
    cyc(12);
    chk("t6_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
